// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    FC_NONE  = 2'b00,
    FC_ALIGN = 2'b01,
    FC_RANGE = 2'b10
  } fault_cause_t;

  localparam int PC_INC = 4;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Width-parameterised saturating up-counter with async active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register and RUN/HALTED/FAULT sequencing driven by EX-stage redirects.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] TRAP_VEC = PC_W'(9'h100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_pc_sel,
  input  logic            ex_halt,
  input  logic [31:0]     ex_br_pc,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            halted,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic [15:0]     redirect_cnt
);

  seq_state_t      state_q, state_d;
  fault_cause_t    cause_q, cause_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush;
  logic            cnt_inc;

  logic take, is_halt, bad_align, bad_range;
  assign take      = ex_valid & ex_pc_sel;
  assign is_halt   = take & ex_halt;
  assign bad_align = ex_br_pc[1:0] != 2'b00;
  assign bad_range = |ex_br_pc[31:PC_W];

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      S_RUN: begin
        flush = take;
        if (is_halt) begin
          pc_d    = ex_br_pc[PC_W-1:0];
          state_d = S_HALTED;
        end else if (take && (bad_align || bad_range)) begin
          pc_d    = TRAP_VEC;
          cause_d = bad_align ? FC_ALIGN : FC_RANGE;
          state_d = S_FAULT;
        end else if (take) begin
          pc_d    = ex_br_pc[PC_W-1:0];
          cnt_inc = 1'b1;
        end else if (!stall) begin
          pc_d = pc_q + PC_W'(PC_INC);
        end
      end
      S_HALTED: begin
        flush = 1'b1;
        if (resume) begin
          pc_d    = pc_q + PC_W'(PC_INC);
          state_d = S_RUN;
        end
      end
      S_FAULT: begin
        flush = 1'b1;
        if (resume) begin
          cause_d = FC_NONE;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cause_q <= FC_NONE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
    end
  end

  sat_counter #(.W(16)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (cnt_inc),
    .cnt_o (redirect_cnt)
  );

  // Gated by reset so flushes read 0 while held in reset, even if EX inputs are live.
  assign flush_if_id = flush & rst_n;
  assign flush_id_ex = flush & rst_n;
  assign pc          = pc_q;
  assign halted      = state_q == S_HALTED;
  assign fault       = state_q == S_FAULT;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: directed plan steps then random traffic against a behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, stall, ex_valid, ex_pc_sel, ex_halt, resume;
  logic [31:0] ex_br_pc;
  logic [8:0]  pc;
  logic        flush_if_id, flush_id_ex, halted, fault;
  logic [1:0]  fault_cause;
  logic [15:0] redirect_cnt;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int m_pc, m_cause, m_cnt;
  bit m_halt, m_flt;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
    .ex_pc_sel(ex_pc_sel), .ex_halt(ex_halt), .ex_br_pc(ex_br_pc),
    .resume(resume), .pc(pc), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .halted(halted), .fault(fault),
    .fault_cause(fault_cause), .redirect_cnt(redirect_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_cause = 0; m_cnt = 0; m_halt = 0; m_flt = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".pc"},     32'(pc),           32'(m_pc));
    chk({tag, ".halted"}, 32'(halted),       32'(m_halt));
    chk({tag, ".fault"},  32'(fault),        32'(m_flt));
    chk({tag, ".cause"},  32'(fault_cause),  32'(m_cause));
    chk({tag, ".cnt"},    32'(redirect_cnt), 32'(m_cnt));
  endtask

  // Called one time unit after a rising edge; applies inputs for one cycle.
  task automatic step(input string tag, input bit st, input bit v, input bit sel,
                      input bit h, input logic [31:0] br, input bit res);
    bit tk;
    stall = st; ex_valid = v; ex_pc_sel = sel; ex_halt = h; ex_br_pc = br; resume = res;
    tk = v && sel;
    #1;
    chk({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(m_halt || m_flt || tk));
    chk({tag, ".flush_id_ex"}, 32'(flush_id_ex), 32'(m_halt || m_flt || tk));
    @(posedge clk);
    if (m_halt) begin
      if (res) begin m_pc = (m_pc + 4) % 512; m_halt = 0; end
    end else if (m_flt) begin
      if (res) begin m_cause = 0; m_flt = 0; end
    end else if (tk && h) begin
      m_pc = br % 512; m_halt = 1;
    end else if (tk && (br % 4 != 0 || br >= 512)) begin
      m_pc = 256; m_cause = (br % 4 != 0) ? 1 : 2; m_flt = 1;
    end else if (tk) begin
      m_pc = br % 512; m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else if (!st) begin
      m_pc = (m_pc + 4) % 512;
    end
    #1;
    chk_state(tag);
  endtask

  initial begin
    rst_n = 1'b1; stall = 0; ex_valid = 0; ex_pc_sel = 0; ex_halt = 0;
    ex_br_pc = '0; resume = 0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk_state("reset");
    chk("reset.flush_if_id", 32'(flush_if_id), 32'(0));
    chk("reset.flush_id_ex", 32'(flush_id_ex), 32'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // sequential fetch 4, 8, 12, 16
    for (int i = 0; i < 4; i++) step("seq", 0, 0, 0, 0, 32'h0, 0);

    // stall holds at 0x010, redirect beats stall
    step("stall0", 1, 0, 0, 0, 32'h0, 0);
    step("stall1", 1, 0, 0, 0, 32'h0, 0);
    step("stall_br", 1, 1, 1, 0, 32'h040, 0);

    // halt, ignored inputs while halted, resume
    step("halt", 0, 1, 1, 1, 32'h024, 0);
    step("halted_ign", 0, 1, 1, 0, 32'h080, 0);
    step("halted_stall", 1, 0, 0, 0, 32'h0, 0);
    step("resume_h", 0, 0, 0, 0, 32'h0, 1);
    step("after_h", 0, 0, 0, 0, 32'h0, 0);
    step("resume_run", 0, 0, 0, 0, 32'h0, 1);

    // misaligned fault (also out of range? no: 0x42 in range)
    step("misalign", 0, 1, 1, 0, 32'h0000_0042, 0);
    step("fault_hold", 0, 1, 1, 0, 32'h0000_0010, 0);
    step("resume_f", 0, 0, 0, 0, 32'h0, 1);
    step("after_f", 0, 0, 0, 0, 32'h0, 0);

    // range fault, and misaligned+range reports alignment
    step("range", 0, 1, 1, 0, 32'h0000_0200, 0);
    step("resume_r", 0, 0, 0, 0, 32'h0, 1);
    step("both_bad", 0, 1, 1, 0, 32'h8000_0003, 0);
    step("resume_b", 0, 0, 0, 0, 32'h0, 1);

    // branch to 0x1FC then wrap to 0
    step("br_1fc", 0, 1, 1, 0, 32'h1FC, 0);
    step("wrap", 0, 0, 0, 0, 32'h0, 0);
    step("pc_sel_novalid", 0, 0, 1, 0, 32'h040, 0);

    // async reset while halted
    step("halt2", 0, 1, 1, 1, 32'h0F0, 0);
    step("halted2", 0, 0, 0, 0, 32'h0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk_state("async_rst");
    chk("async_rst.flush_if_id", 32'(flush_if_id), 32'(0));
    chk("async_rst.flush_id_ex", 32'(flush_id_ex), 32'(0));
    @(negedge clk); rst_n = 1'b1;
    step("post_rst", 0, 0, 0, 0, 32'h0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] br;
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7)       br = 32'($urandom_range(0, 127)) * 32'd4;
      else if (r == 7) br = (32'($urandom_range(0, 127)) * 32'd4) | 32'($urandom_range(1, 3));
      else if (r == 8) br = $urandom | 32'h0000_0200;
      else             br = 32'h1FC;
      step("rand", ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), br,
           ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
